// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings and the controller state enum.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // op[1] distinguishes the divide family from the multiply family.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One combinational iteration shared by multiply and divide.
// Accumulator layout is {upper[WIDTH:0], lower[WIDTH-1:0]}.
//   multiply: shift-add; lower holds the multiplier being consumed LSB-first,
//             upper accumulates the partial product; everything shifts right.
//   divide:   restoring step; upper holds the partial remainder, lower holds
//             the dividend being consumed MSB-first and collects quotient bits.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] opnd,
  input  logic             div_mode,
  output logic [2*WIDTH:0] acc_next,
  output logic             qbit
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] sh;
  logic [WIDTH+1:0] diff;

  // Compute both candidate updates and select by mode.
  always_comb begin
    sum  = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    sh   = {acc[2*WIDTH-1:0], 1'b0};
    diff = {1'b0, sh[2*WIDTH:WIDTH]} - {2'b00, opnd};
    qbit = 1'b0;
    if (div_mode) begin
      // A clear borrow bit means the trial subtraction fits: keep it, q=1.
      qbit = ~diff[WIDTH+1];
      if (qbit) acc_next = {diff[WIDTH:0], sh[WIDTH-1:1], 1'b1};
      else      acc_next = sh;
    end else begin
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Latency WIDTH+1 cycles from start to done (1 cycle for divide by zero).
// Optional build macro MULDIV_SIGNED_EN: op[0] selects signed MULT/DIV;
// when undefined all operations are unsigned and no sign logic exists.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               qbit;
  logic               unused_bits;

`ifdef MULDIV_SIGNED_EN
  logic sn_q;
  logic sn_r;
  logic neg_q;
  logic neg_r;

  function automatic logic [WIDTH-1:0] fix_sign_w(input logic [WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign unused_bits = ^{acc_nxt[2*WIDTH], qbit};
`else
  assign unused_bits = ^{acc_nxt[2*WIDTH], qbit, op[0]};
`endif

  assign busy = (state != MD_IDLE);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .opnd     (opnd),
    .div_mode (div_q),
    .acc_next (acc_nxt),
    .qbit     (qbit)
  );

  // Operand magnitudes and result-sign decisions taken at launch.
  always_comb begin
    a_mag = a;
    b_mag = b;
`ifdef MULDIV_SIGNED_EN
    sn_q = 1'b0;
    sn_r = 1'b0;
    if (op[0]) begin
      a_mag = fix_sign_w(a, a[WIDTH-1]);
      b_mag = fix_sign_w(b, b[WIDTH-1]);
      sn_q  = a[WIDTH-1] ^ b[WIDTH-1];
      sn_r  = a[WIDTH-1];
    end
`endif
  end

  // Final result taken from the last iteration, sign-corrected if needed.
  always_comb begin
    prod = acc_nxt[2*WIDTH-1:0];
    if (div_q) begin
      res_hi = acc_nxt[2*WIDTH-1:WIDTH];
      res_lo = acc_nxt[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
      res_hi = fix_sign_w(res_hi, neg_r);
      res_lo = fix_sign_w(res_lo, neg_q);
`endif
    end else begin
`ifdef MULDIV_SIGNED_EN
      prod = fix_sign_2w(prod, neg_q);
`endif
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Iteration datapath: loaded at launch, advanced once per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == MD_IDLE && start) begin
      acc  <= {{(WIDTH+1){1'b0}}, a_mag};
      opnd <= b_mag;
    end else if (state == MD_RUN) begin
      acc  <= acc_nxt;
    end
  end

  // Controller FSM with registered done/divzero and HI/LO write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      div_q   <= 1'b0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            divzero <= 1'b0;
            div_q   <= md_is_div(op);
            cnt     <= CNT_W'(WIDTH);
`ifdef MULDIV_SIGNED_EN
            neg_q   <= sn_q;
            neg_r   <= sn_r;
`endif
            if (md_is_div(op) && (b == '0)) begin
              state   <= MD_DONE;
              done    <= 1'b1;
              divzero <= 1'b1;
              hi      <= a;
              lo      <= '1;
            end else begin
              state   <= MD_RUN;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MD_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= MD_DONE;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed cases, timing
// windows, HI/LO write strobes, start-while-busy, mid-operation reset and
// randomized operations against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic         divzero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: returns {divzero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0]        p;
    logic signed [63:0] sp;
    logic [31:0]        q;
    logic [31:0]        r;
    bit                 sgn;
    sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`endif
    if (!o[1]) begin
      if (sgn) begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        p  = sp;
      end else begin
        p = {32'b0, x} * {32'b0, y};
      end
      return {1'b0, p};
    end
    if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
    if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {1'b0, r, q};
  endfunction

  // Runs one operation from IDLE; entered and left #1 after a rising edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag);
    logic [64:0] e;
    int exp_cyc;
    int busy_bad;
    int early;
    e = model(o, x, y);
    exp_cyc = (o[1] && y == 32'd0) ? 1 : W + 1;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_bad = 0;
    early = 0;
    for (int cyc = 1; cyc <= exp_cyc; cyc++) begin
      if (busy !== 1'b1) busy_bad++;
      if (cyc < exp_cyc) begin
        if (done === 1'b1) early++;
        @(posedge clk); #1;
      end
    end
    chk({tag, "_busywin"}, 64'(busy_bad), 64'd0);
    chk({tag, "_early"}, 64'(early), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    chk({tag, "_dz"}, 64'(divzero), 64'(e[64]));
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [31:0] hprev;
    logic [31:0] lprev;
    logic [31:0] ra;
    logic [31:0] rb;
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {61'd0, busy, done, divzero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    do_op(2'b10, 32'd100, 32'd7, "divu_100_7");
    do_op(2'b10, 32'd5, 32'd0, "divu_by0");
    do_op(2'b10, 32'd9, 32'd4, "dz_clear");
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minsq");

    // MTHI / MTLO in IDLE
    lprev = lo;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi_lo", 64'(lo), 64'(lprev));
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo", {hi, lo}, 64'h1234_5678_1234_5678);
    lo_we = 1'b1; wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hCAFE_0001);
    chk("mtlo_hi", 64'(hi), 64'h1234_5678);

    // lo_we during RUN is ignored
    lprev = lo;
    op = 2'b00; a = 32'd11; b = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < W + 1; cyc++) begin
      if (cyc == 5) begin lo_we = 1'b1; wdata = 32'h0000_A5A5; end
      if (cyc == 6) begin
        lo_we = 1'b0;
        chk("lowe_run_hold", 64'(lo), 64'(lprev));
      end
      @(posedge clk); #1;
    end
    chk("lowe_run_res", {hi, lo}, 64'd143);
    @(posedge clk); #1;

    // start and hi_we together: start wins
    hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h1111_1111;
    hprev = hi;
    op = 2'b00; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    chk("st_hiwe_c1", 64'(hi), 64'(hprev));
    for (int cyc = 1; cyc < W + 1; cyc++) begin
      @(posedge clk); #1;
    end
    chk("st_hiwe_res", {hi, lo}, 64'd63);
    @(posedge clk); #1;

    // start while busy is ignored
    op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done === 1'b1) dones++;
      if (cyc == 10) begin op = 2'b10; a = 32'd9; b = 32'd3; start = 1'b1; end
      if (cyc == 11) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("busy_start_dones", 64'(dones), 64'd1);
    chk("busy_start_res", {hi, lo}, 64'd6);
    chk("busy_start_idle", 64'(busy), 64'd0);

    // reset during a multiply aborts it immediately
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 32'hFFFF_0000; b = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ctrl", {62'd0, busy, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    do_op(2'b00, 32'd1000, 32'd1000, "post_rst");

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = 32'hFFFF_FFFF;
        3: ra = 32'h8000_0000;
        4: ra = $urandom_range(0, 255);
        default: ;
      endcase
      do_op(2'($urandom_range(0, 3)), ra, rb, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
